// File: rtl/cardinal_processor_pkg.sv
// Shared encodings and helpers for the cardinal vector processor.
//   - opcode / func / element-width encodings
//   - ID->EX pipeline register struct
//   - lane-segmented add/sub and shift helpers used by the EX stage
package cardinal_processor_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 32;

  typedef enum logic [5:0] {
    OP_NOP   = 6'b000000,
    OP_VLD   = 6'b100000,
    OP_VSD   = 6'b100001,
    OP_VBEZ  = 6'b100010,
    OP_VBNEZ = 6'b100011,
    OP_RTYPE = 6'b101010,
    OP_NOP2  = 6'b111100
  } opcode_e;

  typedef enum logic [5:0] {
    F_VAND = 6'b000001,
    F_VOR  = 6'b000010,
    F_VXOR = 6'b000011,
    F_VNOT = 6'b000100,
    F_VMOV = 6'b000101,
    F_VADD = 6'b000110,
    F_VSUB = 6'b000111,
    F_VSLL = 6'b001010,
    F_VSRL = 6'b001011,
    F_VSRA = 6'b001100
  } func_e;

  // 00 = 8x8, 01 = 4x16, 10 = 2x32, 11 = 1x64
  typedef enum logic [1:0] {WW_8 = 2'd0, WW_16 = 2'd1, WW_32 = 2'd2, WW_64 = 2'd3} ww_e;

  // An all-zero value is a bubble: no write, no memory access.
  typedef struct packed {
    logic              we;
    logic              ld;
    logic              st;
    logic [5:0]        func;
    logic [1:0]        ww;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] va;
    logic [DATA_W-1:0] vb;
    logic [DATA_W-1:0] vd;
  } idex_t;

  function automatic logic func_valid(input logic [5:0] f);
    case (f)
      F_VAND, F_VOR, F_VXOR, F_VNOT, F_VMOV,
      F_VADD, F_VSUB, F_VSLL, F_VSRL, F_VSRA: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Byte-wise ripple where the carry is reloaded at every element start,
  // so carries never cross element boundaries. Sub is a + ~b + 1 per element.
  function automatic logic [63:0] vaddsub(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] ww, input logic sub);
    logic [63:0] bb, r;
    logic [8:0]  s;
    logic [2:0]  mask;
    logic        c;
    bb   = sub ? ~b : b;
    mask = 3'((4'd1 << ww) - 4'd1);
    c    = 1'b0;
    r    = '0;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) & mask) == 3'd0) c = sub;
      s = {1'b0, a[8*i +: 8]} + {1'b0, bb[8*i +: 8]} + {8'd0, c};
      r[8*i +: 8] = s[7:0];
      c = s[8];
    end
    return r;
  endfunction

  // Each element is left-aligned in a 64-bit word so one shifter serves every
  // width (sign bit sits at bit 63 for SRA), then the top w bits are taken back.
  function automatic logic [63:0] vshift(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] ww, input logic [5:0] f);
    logic [63:0] r, x, y, bs;
    logic [5:0]  amt;
    int          w, lo;
    w = 8 << ww;
    r = '0;
    for (int e = 0; e < 8; e++) begin
      if (e < 64 / w) begin
        lo  = e * w;
        x   = (a >> lo) << (64 - w);
        bs  = b >> lo;
        amt = bs[5:0] & 6'(w - 1);
        case (f)
          F_VSLL:  y = x << amt;
          F_VSRL:  y = x >> amt;
          default: y = 64'($signed(x) >>> amt);
        endcase
        r = r | ((y >> (64 - w)) << lo);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] valu(input logic [5:0] f, input logic [1:0] ww,
                                       input logic [63:0] a, input logic [63:0] b);
    case (f)
      F_VAND:                 return a & b;
      F_VOR:                  return a | b;
      F_VXOR:                 return a ^ b;
      F_VNOT:                 return ~a;
      F_VMOV:                 return a;
      F_VADD:                 return vaddsub(a, b, ww, 1'b0);
      F_VSUB:                 return vaddsub(a, b, ww, 1'b1);
      F_VSLL, F_VSRL, F_VSRA: return vshift(a, b, ww, f);
      default:                return '0;
    endcase
  endfunction

endpackage

// File: rtl/cardinal_processor_reg_file.sv
// 32 x 64 register file, three read ports (rA, rB, rD) and one write port.
//   Clock, Reset   : clock, async active-high reset (clears all entries)
//   ra/rb/rd_idx   : read addresses;  ra/rb/rd_val : read data
//   we, w_idx, w_data : write port (from WB)
// R0 reads zero and ignores writes. A same-cycle write is bypassed to reads.
module reg_file
  import cardinal_processor_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [REG_AW-1:0] ra_idx,
  input  logic [REG_AW-1:0] rb_idx,
  input  logic [REG_AW-1:0] rd_idx,
  output logic [DATA_W-1:0] ra_val,
  output logic [DATA_W-1:0] rb_val,
  output logic [DATA_W-1:0] rd_val,
  input  logic              we,
  input  logic [REG_AW-1:0] w_idx,
  input  logic [DATA_W-1:0] w_data
);

  logic [DATA_W-1:0] data_arr [0:NUM_REGS-1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) data_arr[i] <= '0;
    end else if (we && w_idx != '0) begin
      data_arr[w_idx] <= w_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] idx);
    if (idx == '0)                return '0;
    else if (we && w_idx == idx)  return w_data;
    else                          return data_arr[idx];
  endfunction

  assign ra_val = rd_port(ra_idx);
  assign rb_val = rd_port(rb_idx);
  assign rd_val = rd_port(rd_idx);

endmodule

// File: rtl/cardinal_processor.sv
// Cardinal 4-stage vector processor: IF, ID (reg read + branch), EX/MEM, WB.
//   Clock, Reset : clock, async active-high reset
//   Instr_Addr   : PC into 256x32 instruction memory (combinational read)
//   Instruction  : fetched word (bit 0 = MSB)
//   Mem_Addr, Data_Out, Data_In : data memory address / store data / load data
//   DmemEn, DmemWrEn : data memory enable / write enable
module cardinal_processor
  import cardinal_processor_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  output logic [0:7]  Instr_Addr,
  input  logic [0:31] Instruction,
  output logic [0:7]  Mem_Addr,
  output logic [0:63] Data_Out,
  input  logic [0:63] Data_In,
  output logic        DmemEn,
  output logic        DmemWrEn
);

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ifid_instr;
  idex_t              ex, ex_nxt;
  logic               wb_we;
  logic [REG_AW-1:0]  wb_rd;
  logic [DATA_W-1:0]  wb_data;

  logic [INSTR_W-1:0] instr_w;
  logic [DATA_W-1:0]  din;
  assign instr_w = Instruction;
  assign din     = Data_In;

  // ---------------- ID ----------------
  logic [5:0]        opc, f_func;
  logic [REG_AW-1:0] f_rd, f_ra, f_rb;
  logic [1:0]        f_ww;
  logic [ADDR_W-1:0] f_imm;
  logic              is_alu, is_ld, is_st, is_bez, is_bnez, is_br;
  logic              stall, taken;
  logic [DATA_W-1:0] ra_val, rb_val, rd_val;

  assign opc    = ifid_instr[31:26];
  assign f_rd   = ifid_instr[25:21];
  assign f_ra   = ifid_instr[20:16];
  assign f_rb   = ifid_instr[15:11];
  assign f_ww   = ifid_instr[7:6];
  assign f_func = ifid_instr[5:0];
  assign f_imm  = ifid_instr[7:0];

  logic unused_bits;
  assign unused_bits = ^ifid_instr[10:8];

  assign is_alu  = (opc == OP_RTYPE);
  assign is_ld   = (opc == OP_VLD);
  assign is_st   = (opc == OP_VSD);
  assign is_bez  = (opc == OP_VBEZ);
  assign is_bnez = (opc == OP_VBNEZ);
  assign is_br   = is_bez | is_bnez;

  // Branches resolve in ID off the register file (WB is covered by the
  // write-through); only a producer still in EX forces a one-cycle wait.
  assign stall = is_br && ex.we && (ex.rd == f_rd);
  assign taken = is_br && !stall && (is_bez ? (rd_val == '0) : (rd_val != '0));

  reg_file rf (
    .Clock (Clock),
    .Reset (Reset),
    .ra_idx(f_ra),
    .rb_idx(f_rb),
    .rd_idx(f_rd),
    .ra_val(ra_val),
    .rb_val(rb_val),
    .rd_val(rd_val),
    .we    (wb_we),
    .w_idx (wb_rd),
    .w_data(wb_data)
  );

  always_comb begin
    ex_nxt      = '0;
    ex_nxt.we   = ((is_alu && func_valid(f_func)) || is_ld) && (f_rd != '0);
    ex_nxt.ld   = is_ld;
    ex_nxt.st   = is_st;
    ex_nxt.func = f_func;
    ex_nxt.ww   = f_ww;
    ex_nxt.rd   = f_rd;
    ex_nxt.ra   = f_ra;
    ex_nxt.rb   = f_rb;
    ex_nxt.imm  = f_imm;
    ex_nxt.va   = ra_val;
    ex_nxt.vb   = rb_val;
    ex_nxt.vd   = rd_val;
  end

  // ---------------- EX/MEM ----------------
  // wb_we is never set for R0, so R0 sources are never forwarded.
  logic [DATA_W-1:0] fa, fb, fd, alu_res;
  assign fa      = (wb_we && wb_rd == ex.ra) ? wb_data : ex.va;
  assign fb      = (wb_we && wb_rd == ex.rb) ? wb_data : ex.vb;
  assign fd      = (wb_we && wb_rd == ex.rd) ? wb_data : ex.vd;
  assign alu_res = valu(ex.func, ex.ww, fa, fb);

  assign DmemEn     = ex.ld | ex.st;
  assign DmemWrEn   = ex.st;
  assign Mem_Addr   = (ex.ld | ex.st) ? ex.imm : '0;
  assign Data_Out   = ex.st ? fd : '0;
  assign Instr_Addr = pc;

  // ---------------- pipeline registers ----------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc         <= '0;
      ifid_instr <= '0;
      ex         <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      if (!stall) begin
        pc         <= taken ? f_imm : pc + 8'd1;
        ifid_instr <= taken ? '0 : instr_w;
      end
      ex      <= stall ? '0 : ex_nxt;
      wb_we   <= ex.we;
      wb_rd   <= ex.rd;
      wb_data <= ex.ld ? din : alu_res;
    end
  end

endmodule

// File: tb/tb_cardinal_processor.sv
module tb_cardinal_processor;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [0:7]  Instr_Addr;
  logic [0:31] Instruction;
  logic [0:7]  Mem_Addr;
  logic [0:63] Data_Out;
  logic [0:63] Data_In;
  logic        DmemEn, DmemWrEn;

  logic [31:0] imem [0:255];
  logic [63:0] dmem [0:255];

  assign Instruction = imem[Instr_Addr];
  assign Data_In     = dmem[Mem_Addr];

  always #5 Clock = ~Clock;

  cardinal_processor dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Instr_Addr (Instr_Addr),
    .Instruction(Instruction),
    .Mem_Addr   (Mem_Addr),
    .Data_Out   (Data_Out),
    .Data_In    (Data_In),
    .DmemEn     (DmemEn),
    .DmemWrEn   (DmemWrEn)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [63:0] d;
  } st_t;
  st_t sb[$];

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [1:0] ww,
                                        input logic [4:0] rd, input logic [4:0] ra,
                                        input logic [4:0] rb);
    return {6'b101010, rd, ra, rb, 3'b000, ww, f};
  endfunction

  function automatic logic [31:0] enc_m(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [7:0] imm);
    return {op, rd, 5'd0, 8'd0, imm};
  endfunction

  task automatic push_st(input logic [7:0] a, input logic [63:0] d);
    st_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // fetch-trace state for the branch checks
  logic [7:0] prev_pc = 8'd0;
  int         cnt7    = 0;
  bit         saw8    = 0;
  bit         seen10  = 0;

  // Called once per cycle on the falling edge: scoreboard stores, track fetch.
  task automatic step();
    st_t e;
    if (DmemEn && DmemWrEn) begin
      if (sb.size() == 0) begin
        chk("sb_extra_store", {56'd0, Mem_Addr}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("st_addr", {56'd0, Mem_Addr}, {56'd0, e.a});
        chk("st_data", Data_Out, e.d);
      end
      dmem[Mem_Addr] = Data_Out;
    end
    if (Instr_Addr == 8'd7) cnt7++;
    if (Instr_Addr == 8'd8) saw8 = 1;
    if (Instr_Addr == 8'd10 && !seen10) begin
      seen10 = 1;
      chk("br_prev_fetch", {56'd0, prev_pc}, 64'd7);
    end
    prev_pc = Instr_Addr;
  endtask

  localparam logic [5:0] VLD = 6'b100000, VSD = 6'b100001, VBEZ = 6'b100010, VBNEZ = 6'b100011;

  logic [63:0] exp_r [0:15];
  logic        any_nz;

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 64'h0;
    end
    dmem[0] = 64'h01FF_01FF_01FF_01FF;
    dmem[1] = 64'h0101_0101_0101_0101;
    dmem[2] = 64'h8000_8000_8000_8000;
    dmem[3] = 64'h0004_0004_0004_0004;

    imem[0]  = enc_m(VLD, 5'd1, 8'd0);
    imem[1]  = enc_m(VLD, 5'd2, 8'd1);
    imem[2]  = enc_r(6'b000110, 2'b00, 5'd3, 5'd1, 5'd2);   // VADD R3,R1,R2 8-bit
    imem[3]  = enc_r(6'b000110, 2'b00, 5'd4, 5'd3, 5'd3);   // VADD R4,R3,R3
    imem[4]  = enc_m(VSD, 5'd4, 8'd5);                      // forwarded store
    imem[5]  = enc_r(6'b000111, 2'b11, 5'd5, 5'd1, 5'd1);   // VSUB R5 = 0
    imem[6]  = enc_m(VBEZ, 5'd5, 8'd10);                    // stall, then taken
    imem[7]  = enc_r(6'b000101, 2'b11, 5'd9, 5'd1, 5'd0);   // flushed
    imem[8]  = enc_r(6'b000101, 2'b11, 5'd9, 5'd1, 5'd0);   // skipped
    imem[9]  = enc_r(6'b000101, 2'b11, 5'd9, 5'd1, 5'd0);   // skipped
    imem[10] = enc_m(VBNEZ, 5'd5, 8'd30);                   // not taken
    imem[11] = enc_m(VLD, 5'd7, 8'd2);
    imem[12] = enc_m(VLD, 5'd8, 8'd3);
    imem[13] = enc_r(6'b001100, 2'b01, 5'd6, 5'd7, 5'd8);   // VSRA 16-bit
    imem[14] = enc_m(VSD, 5'd6, 8'd6);
    imem[15] = enc_r(6'b000110, 2'b11, 5'd10, 5'd1, 5'd2);  // VADD 64-bit
    imem[16] = enc_r(6'b001010, 2'b00, 5'd11, 5'd2, 5'd1);  // VSLL 8-bit
    imem[17] = enc_r(6'b000110, 2'b00, 5'd0, 5'd1, 5'd2);   // write to R0
    imem[18] = enc_m(VSD, 5'd0, 8'd7);                      // must store 0
    imem[19] = enc_r(6'b111111, 2'b00, 5'd12, 5'd1, 5'd2);  // undefined func
    imem[20] = enc_m(VSD, 5'd10, 8'd8);
    imem[21] = 32'h0000_0000;

    push_st(8'd5, 64'h0400_0400_0400_0400);
    push_st(8'd6, 64'hF800_F800_F800_F800);
    push_st(8'd7, 64'h0);
    push_st(8'd8, 64'h0300_0300_0300_0300);

    for (int i = 0; i < 16; i++) exp_r[i] = 64'h0;
    exp_r[1]  = 64'h01FF_01FF_01FF_01FF;
    exp_r[2]  = 64'h0101_0101_0101_0101;
    exp_r[3]  = 64'h0200_0200_0200_0200;
    exp_r[4]  = 64'h0400_0400_0400_0400;
    exp_r[6]  = 64'hF800_F800_F800_F800;
    exp_r[7]  = 64'h8000_8000_8000_8000;
    exp_r[8]  = 64'h0004_0004_0004_0004;
    exp_r[10] = 64'h0300_0300_0300_0300;
    exp_r[11] = 64'h0280_0280_0280_0280;

    // reset held 5 cycles
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    chk("rst_pc", {56'd0, Instr_Addr}, 64'd0);
    chk("rst_en", {62'd0, DmemEn, DmemWrEn}, 64'd0);
    chk("rst_maddr", {56'd0, Mem_Addr}, 64'd0);
    chk("rst_dout", Data_Out, 64'd0);
    any_nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf.data_arr[i] != 64'd0) any_nz = 1;
    chk("rst_regs_zero", {63'd0, any_nz}, 64'd0);

    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("first_fetch_next", {56'd0, Instr_Addr}, 64'd1);
    prev_pc = Instr_Addr;
    step();

    repeat (40) begin
      @(negedge Clock);
      step();
    end

    chk("sb_pending", 64'(sb.size()), 64'd0);
    chk("br_stall_cycles", 64'(cnt7), 64'd2);
    chk("br_skip_8", {63'd0, saw8}, 64'd0);
    chk("br_reached_10", {63'd0, seen10}, 64'd1);
    chk("r0_zero", dut.rf.data_arr[0], 64'd0);
    for (int i = 1; i < 13; i++)
      chk($sformatf("reg_r%0d", i), dut.rf.data_arr[i], exp_r[i]);
    chk("mem5", dmem[5], 64'h0400_0400_0400_0400);

    // reset mid-run: restart, let a few instructions get in flight, reset
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    chk("mid_pre_r1", dut.rf.data_arr[1], 64'h01FF_01FF_01FF_01FF);
    Reset = 1'b1;
    #1;
    chk("mid_rst_en", {62'd0, DmemEn, DmemWrEn}, 64'd0);
    chk("mid_rst_pc", {56'd0, Instr_Addr}, 64'd0);
    chk("mid_rst_r1", dut.rf.data_arr[1], 64'd0);
    repeat (2) @(negedge Clock);
    chk("mid_rst_r2", dut.rf.data_arr[2], 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
